// File: rtl/iq_frame_tx.sv
// Frame buffer that collects buffer_length IQ samples, then streams them out as
// an AXI-Stream style source and waits for the consumer's result before refilling.
module iq_frame_tx #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic signed [i_bits-1:0]     wr_i,
  input  logic signed [q_bits-1:0]     wr_q,
  output logic                         frame_ready,
  output logic                         m_axis_tvalid,
  output logic signed [i_bits-1:0]     xi,
  output logic signed [q_bits-1:0]     xq,
  input  logic                         s_axis_tready,
  output logic [index_bits-1:0]        tx_index,
  output logic                         tlast,
  input  logic                         result_valid,
  output logic                         frame_done
);

  typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;

  localparam int                    word_bits = i_bits + q_bits;
  localparam logic [index_bits-1:0] last_idx  = index_bits'(buffer_length - 1);

  state_t                  state;
  logic [word_bits-1:0]    mem [buffer_length];
  logic [index_bits-1:0]   wr_ptr;
  logic [index_bits-1:0]   next_idx;
  logic [word_bits-1:0]    first_word;
  logic [word_bits-1:0]    next_word;

  assign next_idx = tx_index + index_bits'(1);

  // Sample 0 is being written on the same edge only when the frame is one sample long.
  always_comb begin
    first_word = mem[0];
    if (wr_ptr == '0) first_word = {wr_i, wr_q};
    next_word = mem[next_idx];
  end

  always_ff @(posedge clk) begin
    if (state == FILL && wr_en) mem[wr_ptr] <= {wr_i, wr_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      wr_ptr        <= '0;
      tx_index      <= '0;
      m_axis_tvalid <= 1'b0;
      tlast         <= 1'b0;
      frame_done    <= 1'b0;
      frame_ready   <= 1'b1;
      xi            <= '0;
      xq            <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (wr_en) begin
            if (wr_ptr == last_idx) begin
              wr_ptr        <= '0;
              state         <= SEND;
              frame_ready   <= 1'b0;
              m_axis_tvalid <= 1'b1;
              tx_index      <= '0;
              tlast         <= (last_idx == '0);
              xi            <= first_word[word_bits-1:q_bits];
              xq            <= first_word[q_bits-1:0];
            end else begin
              wr_ptr <= wr_ptr + index_bits'(1);
            end
          end
        end
        SEND: begin
          if (m_axis_tvalid && s_axis_tready) begin
            if (tlast) begin
              m_axis_tvalid <= 1'b0;
              tlast         <= 1'b0;
              state         <= WAIT;
            end else begin
              tx_index <= next_idx;
              tlast    <= (next_idx == last_idx);
              xi       <= next_word[word_bits-1:q_bits];
              xq       <= next_word[q_bits-1:0];
            end
          end
        end
        WAIT: begin
          if (result_valid) begin
            state       <= FILL;
            frame_ready <= 1'b1;
            frame_done  <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_frame_tx.sv
// Directed bench for iq_frame_tx: fill/stream, backpressure, ignored strobes,
// mid-frame reset and extreme sample values.
module tb_iq_frame_tx;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_en;
  logic signed [11:0] wr_i;
  logic signed [11:0] wr_q;
  logic               frame_ready;
  logic               m_axis_tvalid;
  logic signed [11:0] xi;
  logic signed [11:0] xq;
  logic               s_axis_tready;
  logic [3:0]         tx_index;
  logic               tlast;
  logic               result_valid;
  logic               frame_done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic signed [11:0] ei [10];
  logic signed [11:0] eq [10];

  iq_frame_tx #(
    .buffer_length(10),
    .index_bits   (4),
    .i_bits       (12),
    .q_bits       (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_i         (wr_i),
    .wr_q         (wr_q),
    .frame_ready  (frame_ready),
    .m_axis_tvalid(m_axis_tvalid),
    .xi           (xi),
    .xq           (xq),
    .s_axis_tready(s_axis_tready),
    .tx_index     (tx_index),
    .tlast        (tlast),
    .result_valid (result_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Writes ei/eq[start .. start+count-1], one per clock; returns on the negedge after the last write.
  task automatic fill_frame(input int start, input int count);
    for (int k = start; k < start + count; k++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_i  = ei[k];
      wr_q  = eq[k];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulses result_valid for one cycle to leave WAIT.
  task automatic release_wait();
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_i = '0; wr_q = '0;
    s_axis_tready = 1'b0; result_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({frame_ready, m_axis_tvalid, tlast, frame_done, tx_index, xi, xq} !== {4'b1000, 4'd0, 12'd0, 12'd0}) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b v=%b l=%b done=%b idx=%0d i=%0d q=%0d, want rdy=1 others 0",
               frame_ready, m_axis_tvalid, tlast, frame_done, tx_index, xi, xq);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin ei[k] = 12'(k); eq[k] = 12'(-k); end
    s_axis_tready = 1'b1;
    fill_frame(0, 9);
    vectors++;
    if ({frame_ready, m_axis_tvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL stream_pre_last: got rdy=%b v=%b, want rdy=1 v=0", frame_ready, m_axis_tvalid);
    end
    wr_en = 1'b1; wr_i = ei[9]; wr_q = eq[9];
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({m_axis_tvalid, tlast, tx_index, xi, xq, frame_ready} !== {1'b1, k == 9, 4'(k), ei[k], eq[k], 1'b0}) begin
        miscompares++;
        $display("FAIL stream[%0d]: got v=%b l=%b idx=%0d i=%0d q=%0d rdy=%b, want v=1 l=%b idx=%0d i=%0d q=%0d rdy=0",
                 k, m_axis_tvalid, tlast, tx_index, xi, xq, frame_ready, k == 9, k, ei[k], eq[k]);
      end
      @(negedge clk);
    end
    vectors++;
    if ({m_axis_tvalid, tlast, frame_ready, frame_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL stream_end: got v=%b l=%b rdy=%b done=%b, want all 0",
               m_axis_tvalid, tlast, frame_ready, frame_done);
    end
    release_wait();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    for (int k = 0; k < 10; k++) begin ei[k] = 12'(k + 20); eq[k] = 12'(k - 30); end
    s_axis_tready = 1'b0;
    fill_frame(0, 10);
    for (int c = 0; c < 60 && idx < 10; c++) begin
      vectors++;
      if ({m_axis_tvalid, tlast, tx_index, xi, xq} !== {1'b1, idx == 9, 4'(idx), ei[idx], eq[idx]}) begin
        miscompares++;
        $display("FAIL backpressure[c=%0d]: got v=%b l=%b idx=%0d i=%0d q=%0d, want v=1 l=%b idx=%0d i=%0d q=%0d",
                 c, m_axis_tvalid, tlast, tx_index, xi, xq, idx == 9, idx, ei[idx], eq[idx]);
      end
      s_axis_tready = pat[3 - (c % 4)];
      if (s_axis_tready) idx++;
      @(negedge clk);
    end
    s_axis_tready = 1'b0;
    vectors++;
    if (idx != 10 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_end: got transfers=%0d v=%b, want transfers=10 v=0", idx, m_axis_tvalid);
    end
    release_wait();
  endtask

  task automatic test_wr_during_send();
    for (int k = 0; k < 10; k++) begin ei[k] = 12'(3 * k - 7); eq[k] = 12'(100 - k); end
    s_axis_tready = 1'b1;
    fill_frame(0, 10);
    wr_en = 1'b1; wr_i = 12'h7FF; wr_q = 12'h7FF;
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({m_axis_tvalid, tx_index, xi, xq, frame_ready} !== {1'b1, 4'(k), ei[k], eq[k], 1'b0}) begin
        miscompares++;
        $display("FAIL wr_in_send[%0d]: got v=%b idx=%0d i=%0d q=%0d rdy=%b, want v=1 idx=%0d i=%0d q=%0d rdy=0",
                 k, m_axis_tvalid, tx_index, xi, xq, frame_ready, k, ei[k], eq[k]);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    release_wait();
  endtask

  task automatic test_result_valid();
    for (int k = 0; k < 10; k++) begin ei[k] = 12'(k); eq[k] = 12'(-k); end
    s_axis_tready = 1'b1;
    fill_frame(0, 10);
    for (int k = 0; k < 10; k++) begin
      result_valid = (k == 3);
      vectors++;
      if ({m_axis_tvalid, tx_index, frame_done, frame_ready} !== {1'b1, 4'(k), 2'b00}) begin
        miscompares++;
        $display("FAIL rv_in_send[%0d]: got v=%b idx=%0d done=%b rdy=%b, want v=1 idx=%0d done=0 rdy=0",
                 k, m_axis_tvalid, tx_index, frame_done, frame_ready, k);
      end
      @(negedge clk);
    end
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({m_axis_tvalid, frame_ready, frame_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL wait_idle: got v=%b rdy=%b done=%b, want 000", m_axis_tvalid, frame_ready, frame_done);
    end
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    vectors++;
    if ({frame_done, frame_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL wait_release: got done=%b rdy=%b, want done=1 rdy=1", frame_done, frame_ready);
    end
    @(negedge clk);
    vectors++;
    if ({frame_done, frame_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b rdy=%b, want done=0 rdy=1", frame_done, frame_ready);
    end
  endtask

  task automatic test_reset_mid_send();
    for (int k = 0; k < 10; k++) begin ei[k] = 12'(k); eq[k] = 12'(-k); end
    s_axis_tready = 1'b1;
    fill_frame(0, 10);
    repeat (4) @(negedge clk);
    vectors++;
    if ({m_axis_tvalid, tx_index} !== {1'b1, 4'd4}) begin
      miscompares++;
      $display("FAIL pre_reset: got v=%b idx=%0d, want v=1 idx=4", m_axis_tvalid, tx_index);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({m_axis_tvalid, tlast, tx_index, frame_ready} !== {2'b00, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b l=%b idx=%0d rdy=%b, want v=0 l=0 idx=0 rdy=1",
               m_axis_tvalid, tlast, tx_index, frame_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin ei[k] = 12'(100 + k); eq[k] = 12'(-100 - k); end
    fill_frame(0, 10);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({m_axis_tvalid, tlast, tx_index, xi, xq} !== {1'b1, k == 9, 4'(k), ei[k], eq[k]}) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: got v=%b l=%b idx=%0d i=%0d q=%0d, want v=1 l=%b idx=%0d i=%0d q=%0d",
                 k, m_axis_tvalid, tlast, tx_index, xi, xq, k == 9, k, ei[k], eq[k]);
      end
      @(negedge clk);
    end
    release_wait();
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 10; k++) begin
      ei[k] = (k % 2 == 0) ? -12'sd2048 : 12'sd2047;
      eq[k] = (k % 2 == 0) ? 12'sd2047 : -12'sd2048;
    end
    s_axis_tready = 1'b1;
    fill_frame(0, 10);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({m_axis_tvalid, tx_index, xi, xq} !== {1'b1, 4'(k), ei[k], eq[k]}) begin
        miscompares++;
        $display("FAIL extremes[%0d]: got v=%b idx=%0d i=%0d q=%0d, want v=1 idx=%0d i=%0d q=%0d",
                 k, m_axis_tvalid, tx_index, xi, xq, k, ei[k], eq[k]);
      end
      @(negedge clk);
    end
    release_wait();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wr_during_send();
    test_result_valid();
    test_reset_mid_send();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iq_frame_tx.md
IQ_FRAME_TX -- requirements
Module: iq_frame_tx

Interface
REQ-001 Parameter buffer_length, default 10, sets the number of complex samples per frame.
REQ-002 Parameter index_bits, default 4, sets the sample index width; buffer_length SHALL be at most 2^index_bits.
REQ-003 Parameter i_bits, default 12, sets the signed I sample width.
REQ-004 Parameter q_bits, default 12, sets the signed Q sample width.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port wr_en, input, 1 bit: load strobe for one sample into the frame buffer.
REQ-008 Port wr_i, input, i_bits, signed: I sample to load.
REQ-009 Port wr_q, input, q_bits, signed: Q sample to load.
REQ-010 Port frame_ready, output, 1 bit: high in FILL only, meaning the buffer accepts wr_en.
REQ-011 Port m_axis_tvalid, output, 1 bit: the xi/xq stream sample is valid.
REQ-012 Port xi, output, i_bits, signed: streamed I sample.
REQ-013 Port xq, output, q_bits, signed: streamed Q sample.
REQ-014 Port s_axis_tready, input, 1 bit: the downstream consumer accepts the sample.
REQ-015 Port tx_index, output, index_bits: buffer index of the sample currently presented.
REQ-016 Port tlast, output, 1 bit: high while the last sample of the frame (index buffer_length-1) is presented.
REQ-017 Port result_valid, input, 1 bit: the downstream consumer has finished the frame and its result is valid.
REQ-018 Port frame_done, output, 1 bit: one-cycle pulse when result_valid is accepted in WAIT.

Function
REQ-019 The FSM SHALL have exactly three states: FILL, SEND, WAIT.
REQ-020 In FILL, wr_en SHALL write {wr_i, wr_q} to buffer[wr_ptr] and increment wr_ptr.
REQ-021 The write with wr_ptr == buffer_length-1 SHALL move the FSM to SEND on the same edge, reset wr_ptr to 0, and deassert frame_ready.
REQ-022 wr_en outside FILL SHALL be ignored: no buffer write and no pointer change.
REQ-023 m_axis_tvalid SHALL rise on the first cycle in SEND, so the first sample follows the final write by one clock.
REQ-024 A transfer SHALL occur on an edge where m_axis_tvalid and s_axis_tready are both high.
REQ-025 While m_axis_tvalid is high and no transfer occurs, xi, xq, tx_index and tlast SHALL hold stable.
REQ-026 On a transfer with tx_index < buffer_length-1, the next sample SHALL be presented on the next cycle with m_axis_tvalid kept high, so back-to-back transfers run at one sample per clock.
REQ-027 On the transfer with tlast high, m_axis_tvalid SHALL deassert next cycle and the FSM SHALL enter WAIT.
REQ-028 In WAIT, result_valid high SHALL return the FSM to FILL, assert frame_ready next cycle, and pulse frame_done for one cycle.
REQ-029 result_valid outside WAIT SHALL be ignored.
REQ-030 xi, xq and tx_index SHALL be registered outputs driven from the buffer with no combinational path from s_axis_tready.
REQ-031 Buffer contents SHALL NOT change during SEND or WAIT, so samples stream in write order 0..buffer_length-1.
REQ-032 If buffer_length == 1, the single write SHALL enter SEND and tlast SHALL be high on the only sample.

Reset
REQ-033 While rst is high, the state SHALL be FILL, wr_ptr and tx_index SHALL be 0, m_axis_tvalid, tlast and frame_done SHALL be 0, xi and xq SHALL be 0, and frame_ready SHALL be 1.
REQ-034 Reset mid-SEND SHALL drop m_axis_tvalid immediately and asynchronously; the partial frame SHALL be discarded and buffer contents need not be cleared.
REQ-035 After rst deasserts, the first wr_en SHALL write to index 0.

Verification
REQ-036 Fill with 10 samples (i=k, q=-k) while s_axis_tready is held at 1 -> 10 consecutive transfers with xi = 0..9 and xq = 0..-9, tlast only at index 9, and tvalid rising one cycle after the 10th write.
REQ-037 Backpressure: s_axis_tready toggles 1,0,0,1 -> xi, xq and tx_index are held through the low cycles, with no loss or duplication.
REQ-038 wr_en pulsed during SEND with i=0x7FF -> streamed data unchanged and frame_ready stays 0.
REQ-039 result_valid pulsed during SEND is ignored; pulsing it in WAIT -> frame_done for one cycle and frame_ready=1 on the next cycle.
REQ-040 rst asserted at tx_index=4 -> tvalid=0 the same cycle, and the next frame starts streaming at index 0.
REQ-041 Extreme values i=-2048, q=2047 -> streamed bit-exact.
